// File: rtl/cafeteira_status_tx.sv
// Serial status reporter for the coffee machine: latches control-unit events and
// sends each one to the ESP as a 3-byte ASCII frame ('#', code, LF) on an 8N1 line.
module cafeteira_status_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       evt_timeout_ebulidor,
    input  logic       evt_sem_xicara,
    input  logic       evt_pronto,
    input  logic       pede_estado,
    input  logic [4:0] estado,
    output logic       tx,
    output logic       ocupado,
    output logic       fim_envio,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        INICIO  = 3'd2,
        DADOS   = 3'd3,
        PARADA  = 3'd4,
        FIM     = 3'd5
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    // pend bits: [3]=E timeout, [2]=X no cup, [1]=P ready, [0]=S state report
    function automatic logic [7:0] code_byte(input logic [3:0] pend, input logic [4:0] est);
        logic [7:0] c;
        if (pend[3]) begin
            c = 8'h45;
        end else if (pend[2]) begin
            c = 8'h58;
        end else if (pend[1]) begin
            c = 8'h50;
        end else if (pend[0] && (est <= 5'd20)) begin
            c = 8'h41 + {3'b000, est};
        end else begin
            c = 8'h3F;
        end
        return c;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [7:0] code);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h23;
            2'd1:    b = code;
            2'd2:    b = 8'h0A;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    state_t      state_r, state_nx_s;
    logic [3:0]  pend_r, pend_nx_s, grant_s, clear_s;
    logic        pronto_prev_r;
    logic [15:0] baud_cnt_r, baud_cnt_nx_s;
    logic [2:0]  bit_cnt_r, bit_cnt_nx_s;
    logic [1:0]  byte_idx_r, byte_idx_nx_s;
    logic [7:0]  shift_r, shift_nx_s, code_r, code_nx_s;
    logic        baud_done_s;
    logic        tx_r, tx_nx_s, ocupado_r, ocupado_nx_s, fim_envio_r, fim_nx_s;
    logic [2:0]  db_estado_r, db_nx_s;

    assign baud_done_s = (baud_cnt_r == BAUD_LAST);

    // Fixed-priority grant E > X > P > S
    always_comb begin
        grant_s = 4'b0000;
        if (pend_r[3]) begin
            grant_s = 4'b1000;
        end else if (pend_r[2]) begin
            grant_s = 4'b0100;
        end else if (pend_r[1]) begin
            grant_s = 4'b0010;
        end else if (pend_r[0]) begin
            grant_s = 4'b0001;
        end else begin
            grant_s = 4'b0000;
        end
    end

    // New events OR in after the clear, so a same-type event during CARREGA is kept
    assign pend_nx_s = (pend_r & ~clear_s) |
                       {evt_timeout_ebulidor, evt_sem_xicara, evt_pronto & ~pronto_prev_r, pede_estado};

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            OCIOSO:  state_nx_s = (|pend_r) ? CARREGA : OCIOSO;
            CARREGA: state_nx_s = INICIO;
            INICIO:  state_nx_s = baud_done_s ? DADOS : INICIO;
            DADOS:   state_nx_s = (baud_done_s && (bit_cnt_r == 3'd7)) ? PARADA : DADOS;
            PARADA: begin
                if (baud_done_s) begin
                    state_nx_s = (byte_idx_r < 2'd2) ? INICIO : FIM;
                end else begin
                    state_nx_s = PARADA;
                end
            end
            FIM:     state_nx_s = OCIOSO;
            default: state_nx_s = OCIOSO;
        endcase
    end

    // Datapath next values: baud/bit counters, byte index, shift and code registers
    always_comb begin
        clear_s       = 4'b0000;
        baud_cnt_nx_s = baud_cnt_r;
        bit_cnt_nx_s  = bit_cnt_r;
        byte_idx_nx_s = byte_idx_r;
        shift_nx_s    = shift_r;
        code_nx_s     = code_r;
        case (state_r)
            CARREGA: begin
                clear_s       = grant_s;
                code_nx_s     = code_byte(pend_r, estado);
                byte_idx_nx_s = 2'd0;
                shift_nx_s    = frame_byte(2'd0, 8'h00);
                baud_cnt_nx_s = 16'd0;
            end
            INICIO: begin
                if (baud_done_s) begin
                    baud_cnt_nx_s = 16'd0;
                    bit_cnt_nx_s  = 3'd0;
                end else begin
                    baud_cnt_nx_s = baud_cnt_r + 16'd1;
                end
            end
            DADOS: begin
                if (baud_done_s) begin
                    baud_cnt_nx_s = 16'd0;
                    bit_cnt_nx_s  = bit_cnt_r + 3'd1;
                    shift_nx_s    = {1'b0, shift_r[7:1]};
                end else begin
                    baud_cnt_nx_s = baud_cnt_r + 16'd1;
                end
            end
            PARADA: begin
                if (baud_done_s) begin
                    baud_cnt_nx_s = 16'd0;
                    if (byte_idx_r < 2'd2) begin
                        byte_idx_nx_s = byte_idx_r + 2'd1;
                        shift_nx_s    = frame_byte(byte_idx_r + 2'd1, code_r);
                    end else begin
                        byte_idx_nx_s = byte_idx_r;
                    end
                end else begin
                    baud_cnt_nx_s = baud_cnt_r + 16'd1;
                end
            end
            default: baud_cnt_nx_s = 16'd0;
        endcase
    end

    // Output decode of the upcoming state, so every output comes straight from a flop
    always_comb begin
        tx_nx_s = 1'b1;
        case (state_nx_s)
            INICIO:  tx_nx_s = 1'b0;
            DADOS:   tx_nx_s = shift_nx_s[0];
            default: tx_nx_s = 1'b1;
        endcase
        ocupado_nx_s = (state_nx_s != OCIOSO);
        fim_nx_s     = (state_nx_s == FIM);
        db_nx_s      = state_nx_s;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= OCIOSO;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_r        <= 4'b0000;
            pronto_prev_r <= 1'b0;
            baud_cnt_r    <= 16'd0;
            bit_cnt_r     <= 3'd0;
            byte_idx_r    <= 2'd0;
            shift_r       <= 8'h00;
            code_r        <= 8'h00;
            tx_r          <= 1'b1;
            ocupado_r     <= 1'b0;
            fim_envio_r   <= 1'b0;
            db_estado_r   <= 3'd0;
        end else begin
            pend_r        <= pend_nx_s;
            pronto_prev_r <= evt_pronto;
            baud_cnt_r    <= baud_cnt_nx_s;
            bit_cnt_r     <= bit_cnt_nx_s;
            byte_idx_r    <= byte_idx_nx_s;
            shift_r       <= shift_nx_s;
            code_r        <= code_nx_s;
            tx_r          <= tx_nx_s;
            ocupado_r     <= ocupado_nx_s;
            fim_envio_r   <= fim_nx_s;
            db_estado_r   <= db_nx_s;
        end
    end

    assign tx        = tx_r;
    assign ocupado   = ocupado_r;
    assign fim_envio = fim_envio_r;
    assign db_estado = db_estado_r;

endmodule
